// File: rtl/motion_pkg.sv
// Shared definitions for the player motion path: state encoding, datapath widths
// and default physics constants also referenced by the death detector and renderer.
package motion_pkg;

    localparam int VEL_W    = 6;
    localparam int HEIGHT_W = 9;
    localparam int CALC_W   = 11;

    localparam logic [HEIGHT_W-1:0] H_START_DEF  = 9'd240;
    localparam int                  GRAVITY_DEF  = 1;
    localparam int                  FLAP_VEL_DEF = 8;
    localparam int                  VMAX_DEF     = 10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_DEAD = 2'd2
    } state_e;

    // Saturate a signed intermediate height into the unsigned screen range.
    function automatic logic [HEIGHT_W-1:0] clamp_height(input logic signed [CALC_W-1:0] h);
        if (h < 0) begin
            return '0;
        end else if (h[CALC_W-2:HEIGHT_W] != '0) begin
            return '1;
        end else begin
            return h[HEIGHT_W-1:0];
        end
    endfunction

endpackage

// File: rtl/rise_detect.sv
// Registered rising-edge pulse generator; load_i re-seeds the history with the
// current level so a level already high at that moment produces no pulse.
module rise_detect (
    input  logic clk,
    input  logic reset,
    input  logic load_i,
    input  logic level_i,
    output logic rise_o
);

    logic prev_q;
    logic rise_q;
    logic rise_d;

    always_comb begin
        rise_d = level_i & ~prev_q;
        if (load_i) begin
            rise_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            prev_q <= level_i;
            rise_q <= rise_d;
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/player_motion.sv
// Per-frame player height/velocity integrator with flap and gravity.
// Optional FLAP_COOLDOWN_EN adds a post-flap window in which new flaps are discarded.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | waiting for start; height held at H_START, velocity 0
// ST_PLAY | integrating velocity/height on every frame_tick
// ST_DEAD | frozen after is_dead; start returns to ST_IDLE
module player_motion
    import motion_pkg::*;
#(
    parameter logic [HEIGHT_W-1:0] H_START  = H_START_DEF,
    parameter int                  GRAVITY  = GRAVITY_DEF,
    parameter int                  FLAP_VEL = FLAP_VEL_DEF,
    parameter int                  VMAX     = VMAX_DEF
`ifdef FLAP_COOLDOWN_EN
    , parameter int                COOLDOWN_FRAMES = 4
`endif
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       frame_tick,
    input  logic                       start,
    input  logic                       flap,
    input  logic                       is_dead,
    output logic [HEIGHT_W-1:0]        height,
    output logic                       in_game,
    output logic signed [VEL_W-1:0]    velocity,
    output logic [1:0]                 state
);

    localparam logic signed [VEL_W:0]   GRAV_V   = (VEL_W+1)'(GRAVITY);
    localparam logic signed [VEL_W:0]   VMAX_V   = (VEL_W+1)'(VMAX);
    localparam logic signed [VEL_W-1:0] VMAX_SAT = VEL_W'(VMAX);
    localparam logic signed [VEL_W-1:0] FLAP_NEG = VEL_W'(-FLAP_VEL);

    state_e                     state_q, state_d;
    logic [HEIGHT_W-1:0]        height_q, height_d;
    logic signed [VEL_W-1:0]    vel_q, vel_d;
    logic                       in_game_q;
    logic                       pending_q, pending_d;

    logic                       flap_rise;
    logic                       flap_accept;
    logic                       rise_load;
    logic signed [VEL_W:0]      vel_sum;
    logic signed [VEL_W-1:0]    vel_new;
    logic signed [CALC_W-1:0]   h_sum;

`ifdef FLAP_COOLDOWN_EN
    localparam logic [7:0] CD_LOAD = 8'(COOLDOWN_FRAMES);
    logic [7:0] cd_q, cd_d;
`endif

    // Seed the edge history on the IDLE->PLAY transition so a held button is not a flap.
    assign rise_load = (state_q == ST_IDLE) && start;

    rise_detect u_flap_rise (
        .clk     (clk),
        .reset   (reset),
        .load_i  (rise_load),
        .level_i (flap),
        .rise_o  (flap_rise)
    );

`ifdef FLAP_COOLDOWN_EN
    assign flap_accept = flap_rise && (cd_q == '0);
`else
    assign flap_accept = flap_rise;
`endif

    assign vel_sum = $signed({vel_q[VEL_W-1], vel_q}) + GRAV_V;
    assign vel_new = pending_q ? FLAP_NEG :
                     (vel_sum > VMAX_V) ? VMAX_SAT : vel_sum[VEL_W-1:0];
    assign h_sum   = $signed({2'b00, height_q}) +
                     $signed({{(CALC_W-VEL_W){vel_new[VEL_W-1]}}, vel_new});

    always_comb begin
        state_d   = state_q;
        height_d  = height_q;
        vel_d     = vel_q;
        pending_d = pending_q;
`ifdef FLAP_COOLDOWN_EN
        cd_d      = cd_q;
`endif
        case (state_q)
            ST_IDLE: begin
                height_d  = H_START;
                vel_d     = '0;
                pending_d = 1'b0;
                if (start) begin
                    state_d = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (is_dead) begin
                    state_d   = ST_DEAD;
                    pending_d = 1'b0;
`ifdef FLAP_COOLDOWN_EN
                    cd_d      = '0;
`endif
                end else if (frame_tick) begin
                    vel_d     = vel_new;
                    height_d  = clamp_height(h_sum);
                    // An edge landing on the tick cycle is kept for the next frame.
                    pending_d = flap_accept;
`ifdef FLAP_COOLDOWN_EN
                    if (pending_q) begin
                        cd_d = CD_LOAD;
                    end else if (cd_q != '0) begin
                        cd_d = cd_q - 8'd1;
                    end
`endif
                end else begin
                    pending_d = pending_q | flap_accept;
                end
            end
            ST_DEAD: begin
                if (start) begin
                    state_d  = ST_IDLE;
                    height_d = H_START;
                    vel_d    = '0;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                height_d  = H_START;
                vel_d     = '0;
                pending_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            height_q  <= H_START;
            vel_q     <= '0;
            in_game_q <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            height_q  <= height_d;
            vel_q     <= vel_d;
            in_game_q <= (state_d == ST_PLAY);
            pending_q <= pending_d;
        end
    end

`ifdef FLAP_COOLDOWN_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            cd_q <= '0;
        end else begin
            cd_q <= cd_d;
        end
    end
`endif

    assign height   = height_q;
    assign velocity = vel_q;
    assign in_game  = in_game_q;
    assign state    = state_q;

endmodule

// File: tb/tb_player_motion.sv
// Self-checking bench for player_motion: directed frames plus randomized frames
// compared against a per-frame behavioural model of the game physics.
module tb_player_motion;

    localparam int H0  = 240;
    localparam int G   = 1;
    localparam int FV  = 8;
    localparam int VM  = 10;
    localparam int CDN = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              frame_tick = 1'b0;
    logic              start = 1'b0;
    logic              flap = 1'b0;
    logic              is_dead = 1'b0;
    logic [8:0]        height;
    logic              in_game;
    logic signed [5:0] velocity;
    logic [1:0]        state;

    int checks = 0;
    int errors = 0;

    // model: mode 0=idle 1=play 2=dead
    int m_mode, m_h, m_v, m_cd;

    always #5 clk = ~clk;

    player_motion dut (
        .clk        (clk),
        .reset      (reset),
        .frame_tick (frame_tick),
        .start      (start),
        .flap       (flap),
        .is_dead    (is_dead),
        .height     (height),
        .in_game    (in_game),
        .velocity   (velocity),
        .state      (state)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic int clampi(input int x);
        if (x < 0) return 0;
        if (x > 511) return 511;
        return x;
    endfunction

    task automatic check_all(input string tag);
        check({tag, ".state"},   int'(state),    m_mode);
        check({tag, ".height"},  int'(height),   m_h);
        check({tag, ".vel"},     int'(velocity), m_v);
        check({tag, ".in_game"}, int'(in_game),  (m_mode == 1) ? 1 : 0);
    endtask

    task automatic model_reset();
        m_mode = 0; m_h = H0; m_v = 0; m_cd = 0;
    endtask

    task automatic do_start();
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        if (m_mode == 0) begin
            m_mode = 1; m_h = H0; m_v = 0;
        end else if (m_mode == 2) begin
            m_mode = 0; m_h = H0; m_v = 0; m_cd = 0;
        end
        check_all("start");
        cyc(1);
    endtask

    // One frame: nflap button presses, settle, then a tick (optionally with is_dead).
    task automatic do_frame(input int nflap, input bit dead);
        bit pend;
        pend = 1'b0;
        for (int i = 0; i < nflap; i++) begin
            flap = 1'b1;
            cyc(1);
            flap = 1'b0;
            cyc(1);
            if (m_mode == 1 && m_cd == 0) pend = 1'b1;
        end
        cyc(3);
        check_all("pre_tick");
        frame_tick = 1'b1;
        is_dead = dead;
        cyc(1);
        frame_tick = 1'b0;
        is_dead = 1'b0;
        if (m_mode == 1) begin
            if (dead) begin
                m_mode = 2;
                m_cd = 0;
            end else begin
                if (pend) begin
                    m_v = -FV;
`ifdef FLAP_COOLDOWN_EN
                    m_cd = CDN;
`endif
                end else begin
                    m_v = (m_v + G > VM) ? VM : m_v + G;
                    if (m_cd > 0) m_cd--;
                end
                m_h = clampi(m_h + m_v);
            end
        end
        check_all("tick");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        reset = 1'b1;
        cyc(3);
        check("rst.state",  int'(state),    0);
        check("rst.height", int'(height),   240);
        check("rst.vel",    int'(velocity), 0);
        check("rst.in_game", int'(in_game), 0);
        reset = 1'b0;
        cyc(1);

        // free fall from start
        do_start();
        for (int t = 1; t <= 3; t++) do_frame(0, 0);
        check("tp1.vel", int'(velocity), 3);
        check("tp1.height", int'(height), 246);
        do_frame(0, 1);
        do_start();

        // single flap then gravity
        do_start();
        do_frame(1, 0);
        check("tp2.vel1", int'(velocity), -8);
        check("tp2.h1",   int'(height), 232);
        do_frame(0, 0);
        check("tp2.vel2", int'(velocity), -7);
        check("tp2.h2",   int'(height), 225);
        do_frame(2, 0);
        do_frame(0, 1);
        do_start();

        // velocity saturation and bottom clamp
        do_start();
        for (int t = 1; t <= 35; t++) begin
            do_frame(0, 0);
            if (t == 10) check("tp3.h10", int'(height), 295);
            if (t == 15) check("tp3.h15", int'(height), 345);
        end
        check("tp3.vmax", int'(velocity), 10);
        check("tp3.hmax", int'(height), 511);

        // death on a tick cycle freezes everything
        do_frame(0, 1);
        check("tp4.state", int'(state), 2);
        check("tp4.h",     int'(height), 511);
        for (int t = 0; t < 3; t++) do_frame(1, 0);
        do_start();
        check("tp4.idle_h", int'(height), 240);

        // flap every frame, top clamp
        do_start();
        for (int t = 1; t <= 31; t++) do_frame(1, 0);
`ifndef FLAP_COOLDOWN_EN
        check("tp5.h0", int'(height), 0);
`endif
        do_frame(0, 1);
        do_start();

        // button already held at start is not a flap
        flap = 1'b1;
        do_start();
        do_frame(0, 0);
        flap = 1'b0;
        do_frame(0, 0);
        check("held.vel", int'(velocity), 2);

        // reset mid-play
        for (int t = 0; t < 4; t++) do_frame(0, 0);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        model_reset();
        check_all("midrst");
        check("midrst.h", int'(height), 240);
        cyc(1);

`ifdef FLAP_COOLDOWN_EN
        do_start();
        for (int t = 1; t <= 6; t++) begin
            do_frame(1, 0);
            if (t == 1) check("cd.t1", int'(velocity), -8);
            if (t == 5) check("cd.t5", int'(velocity), -4);
            if (t == 6) check("cd.t6", int'(velocity), -8);
        end
        do_frame(0, 1);
        do_start();
`endif

        // randomized frames against the model
        for (int f = 0; f < 400; f++) begin
            int r;
            r = $urandom_range(0, 99);
            if (m_mode != 1 && r < 40) begin
                do_start();
            end else if (m_mode == 1 && r < 3) begin
                do_start();
            end else begin
                do_frame($urandom_range(0, 2) == 0 ? 0 : $urandom_range(1, 3),
                         ($urandom_range(0, 39) == 0));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/player_motion.md
Name: player_motion

Overview:
- Generates the player's top-edge height each frame from flap input and gravity.
- Produces the `height` and `in_game` signals that the death detector consumes, and reacts to its `is_dead` result by freezing the player.
- Sits between the input debouncer/frame timer and the death detector/renderer.
- Height is a screen y coordinate: it grows downward, so gravity increases it and a flap decreases it.

Parameters:
- H_START, 240, height loaded in IDLE and on reset.
- GRAVITY, 1, velocity increment per frame tick.
- FLAP_VEL, 8, magnitude of upward velocity set by a flap (velocity becomes -FLAP_VEL).
- VMAX, 10, maximum downward velocity.
- COOLDOWN_FRAMES, 4, frames flaps are ignored after an accepted flap (only with the optional feature).

Ports:
- clk  input  1  system clock.
- reset  input  1  reset is synchronous and active-high.
- frame_tick  input  1  one-cycle pulse once per video frame.
- start  input  1  one-cycle pulse, start/restart request.
- flap  input  1  debounced button level.
- is_dead  input  1  death flag from the death detector.
- height  output  9  player top-edge y, unsigned.
- in_game  output  1  high only in PLAY.
- velocity  output  6  signed vertical velocity, positive is downward.
- state  output  2  current FSM state (debug/renderer).

Behaviour:
- Reset values: state=IDLE, height=H_START, velocity=0, in_game=0, flap_pending=0, cooldown=0.
- All outputs are registered.
- States: IDLE=0, PLAY=1, DEAD=2.
- IDLE:
  - height is held at H_START and velocity at 0.
  - A start pulse moves to PLAY next cycle; velocity stays 0.
- PLAY:
  - in_game=1.
  - A rising edge of flap sets flap_pending. Multiple edges between ticks count once.
  - On frame_tick with flap_pending: velocity=-FLAP_VEL, flap_pending cleared.
  - On frame_tick without flap_pending: velocity=min(velocity+GRAVITY, VMAX).
  - On frame_tick, height updates in the same cycle using the new velocity: height_next = height + velocity_new.
  - Height arithmetic is done in 11-bit signed, then clamped to 0..511.
  - start pulses are ignored in PLAY.
- PLAY -> DEAD when is_dead=1. This takes priority over a same-cycle frame_tick: no height or velocity update that cycle.
- DEAD:
  - in_game=0; height and velocity are frozen and flap is ignored.
  - A start pulse moves to IDLE next cycle: height=H_START, velocity=0.
- Latency: height changes exactly one clk after the frame_tick cycle.
- reset at any time, including mid-PLAY, forces reset values on the next edge.
- The flap edge detector is initialised to the current flap level on entry to PLAY, so a button already held does not generate a flap.
- Parameter legality: FLAP_VEL and VMAX must each be ≤31, so they fit the signed 6-bit velocity.

Optional Feature:
- Macro: FLAP_COOLDOWN_EN.
- Defined:
  - An accepted flap (applied at a tick) loads cooldown=COOLDOWN_FRAMES.
  - cooldown decrements on each subsequent tick.
  - Flap edges arriving while cooldown≠0 are discarded.
  - cooldown is cleared on leaving PLAY.
- Undefined:
  - No cooldown register; every flap edge sets flap_pending.
  - COOLDOWN_FRAMES is unused.

Decomposition:
- Shared package `motion_pkg` holds:
  - the state enum encoding (IDLE/PLAY/DEAD);
  - VEL_W=6 and HEIGHT_W=9;
  - default H_START/GRAVITY/FLAP_VEL/VMAX constants, which the death detector's bounds and the renderer also reference.
- One sub-module: `rise_detect`, a registered rising-edge pulse generator for flap with a load input for the PLAY-entry initialisation.

Test Plan (default parameters, macro undefined unless stated):
- Reset, start, then 3 ticks with no flap -> velocity 1,2,3; height 241,243,246; in_game=1.
- start, one flap pulse, then tick -> velocity=-8, height=232; next tick with no flap -> velocity=-7, height=225.
- start, 15 ticks with no flap and is_dead forced 0 -> velocity saturates at 10 from tick 10; height rises by 10 per tick thereafter (tick 10 height 295, tick 15 height 345).
- In PLAY, assert is_dead on the same cycle as frame_tick -> state=DEAD, height unchanged, in_game=0; 3 more ticks give no change; start -> IDLE with height=240, velocity=0.
- Flap before every tick with is_dead held 0 -> height 232,224,…,0 after 30 ticks; the 31st tick holds height at 0 (clamp, no wrap).
- Reset mid-PLAY with height=260 -> next cycle state=IDLE, height=240, velocity=0, in_game=0.
- With FLAP_COOLDOWN_EN: flap before each of 6 ticks -> flaps applied at ticks 1 and 6; ticks 2–5 follow gravity.
